// File: rtl/ipm2t_hssthp_cfg_arbiter_v1_0_if.sv
// Bundle of the two requester ports, the APB master port toward the HSSTHP
// bridge and the busy flag. The arbiter uses the slave view (it serves the
// requesters and drives the APB side); the environment uses the master view.
interface ipm2t_hssthp_cfg_arbiter_v1_0_if;
    // requester 0 (init/DRP sequencer)
    logic        req0_valid;
    logic        req0_write;
    logic [15:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        req0_ready;
    logic        req0_done;
    logic        req0_err;
    logic [7:0]  req0_rdata;
    // requester 1 (user logic)
    logic        req1_valid;
    logic        req1_write;
    logic [15:0] req1_addr;
    logic [7:0]  req1_wdata;
    logic        req1_ready;
    logic        req1_done;
    logic        req1_err;
    logic [7:0]  req1_rdata;
    // APB toward the bridge
    logic        p_cfg_psel;
    logic        p_cfg_enable;
    logic        p_cfg_write;
    logic [15:0] p_cfg_addr;
    logic [7:0]  p_cfg_wdata;
    logic        p_cfg_ready;
    logic [7:0]  p_cfg_rdata;
    // status
    logic        cfg_busy;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_err, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_err, req1_rdata,
        input  p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata,
        output p_cfg_ready, p_cfg_rdata,
        input  cfg_busy
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_err, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_err, req1_rdata,
        output p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata,
        input  p_cfg_ready, p_cfg_rdata,
        output cfg_busy
    );
endinterface

// File: rtl/ipm2t_hssthp_cfg_arbiter_v1_0.sv
// Two-requester APB master arbiter/sequencer in front of the HSSTHP APB
// bridge. Round-robin on ties, generates SETUP/ACCESS itself, bounds the
// ACCESS phase with a ready timeout and answers unmapped targets locally.
// Every transaction ends with one done pulse to its owner.
module ipm2t_hssthp_cfg_arbiter_v1_0 #(
    parameter int TIMEOUT = 255
) (
    input  logic p_cfg_clk,
    input  logic p_cfg_rstn,
    ipm2t_hssthp_cfg_arbiter_v1_0_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // last counter value before giving up on p_cfg_ready
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);
    // highest mapped target: channels 0..3 and the HPLL at 4
    localparam logic [3:0] LAST_TARGET = 4'd4;

    // requester ports gathered into index-addressable vectors
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][15:0] req_addr;
    logic [1:0][7:0]  req_wdata;
    logic [1:0]       req_ready;

    state_t           state_reg, state_next;
    logic             last_gnt_reg, last_gnt_next;
    logic             owner_reg, owner_next;
    logic [7:0]       count_reg, count_next;
    logic             psel_reg, psel_next;
    logic             enable_reg, enable_next;
    logic             write_reg, write_next;
    logic [15:0]      addr_reg, addr_next;
    logic [7:0]       wdata_reg, wdata_next;
    logic             busy_reg, busy_next;
    logic [1:0]       done_reg, done_next;
    logic [1:0]       err_reg, err_next;
    logic [1:0][7:0]  rdata_reg, rdata_next;

    logic             grant_any;
    logic             grant_idx;

    assign req_valid    = {bus.req1_valid, bus.req0_valid};
    assign req_write    = {bus.req1_write, bus.req0_write};
    assign req_addr[0]  = bus.req0_addr;
    assign req_addr[1]  = bus.req1_addr;
    assign req_wdata[0] = bus.req0_wdata;
    assign req_wdata[1] = bus.req1_wdata;

    // Pick a requester: a lone valid wins, a tie goes to the one not served last.
    always_comb begin
        grant_any = |req_valid;
        grant_idx = 1'b0;
        case (req_valid)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_gnt_reg;
            default: grant_idx = 1'b0;
        endcase
    end

    // Ready is only ever offered in IDLE, and only to the granted requester.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && grant_any &&
                                   (grant_idx == 1'(gi));
        end
    endgenerate

    // Next-state and next-output logic; every register holds unless told otherwise.
    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        owner_next    = owner_reg;
        count_next    = count_reg;
        psel_next     = psel_reg;
        enable_next   = enable_reg;
        write_next    = write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        done_next     = 2'b00;
        err_next      = err_reg;
        rdata_next    = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    owner_next    = grant_idx;
                    last_gnt_next = grant_idx;
                    write_next    = req_write[grant_idx];
                    addr_next     = req_addr[grant_idx];
                    wdata_next    = req_wdata[grant_idx];
                    if (req_addr[grant_idx][15:12] <= LAST_TARGET) begin
                        state_next = SETUP;
                        psel_next  = 1'b1;
                    end else begin
                        // unmapped target: answer locally, never touch the bridge
                        state_next             = RESP;
                        done_next[grant_idx]  = 1'b1;
                        err_next[grant_idx]   = 1'b1;
                        rdata_next[grant_idx] = 8'h00;
                    end
                end
            end

            SETUP: begin
                state_next  = ACCESS;
                enable_next = 1'b1;
                count_next  = 8'd0;
            end

            ACCESS: begin
                if (bus.p_cfg_ready) begin
                    // a ready on the limit cycle still counts as success
                    state_next             = RESP;
                    psel_next              = 1'b0;
                    enable_next            = 1'b0;
                    done_next[owner_reg]  = 1'b1;
                    err_next[owner_reg]   = 1'b0;
                    rdata_next[owner_reg] = write_reg ? 8'h00 : bus.p_cfg_rdata;
                end else if (count_reg == CNT_LIMIT) begin
                    state_next             = RESP;
                    psel_next              = 1'b0;
                    enable_next            = 1'b0;
                    done_next[owner_reg]  = 1'b1;
                    err_next[owner_reg]   = 1'b1;
                    rdata_next[owner_reg] = 8'h00;
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge p_cfg_clk or negedge p_cfg_rstn) begin
        if (!p_cfg_rstn) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            owner_reg    <= 1'b0;
            count_reg    <= 8'd0;
            psel_reg     <= 1'b0;
            enable_reg   <= 1'b0;
            write_reg    <= 1'b0;
            addr_reg     <= 16'h0000;
            wdata_reg    <= 8'h00;
            busy_reg     <= 1'b0;
            done_reg     <= 2'b00;
            err_reg      <= 2'b00;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
            owner_reg    <= owner_next;
            count_reg    <= count_next;
            psel_reg     <= psel_next;
            enable_reg   <= enable_next;
            write_reg    <= write_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign bus.req0_ready   = req_ready[0];
    assign bus.req1_ready   = req_ready[1];
    assign bus.req0_done    = done_reg[0];
    assign bus.req1_done    = done_reg[1];
    assign bus.req0_err     = err_reg[0];
    assign bus.req1_err     = err_reg[1];
    assign bus.req0_rdata   = rdata_reg[0];
    assign bus.req1_rdata   = rdata_reg[1];
    assign bus.p_cfg_psel   = psel_reg;
    assign bus.p_cfg_enable = enable_reg;
    assign bus.p_cfg_write  = write_reg;
    assign bus.p_cfg_addr   = addr_reg;
    assign bus.p_cfg_wdata  = wdata_reg;
    assign bus.cfg_busy     = busy_reg;

endmodule

// File: tb/tb_ipm2t_hssthp_cfg_arbiter_v1_0.sv
// Bench for the HSSTHP config arbiter: directed scenarios plus random
// traffic, checked every cycle against a transaction-timeline model.
module tb_ipm2t_hssthp_cfg_arbiter_v1_0;
    localparam int TIMEOUT = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ipm2t_hssthp_cfg_arbiter_v1_0_if bus ();

    ipm2t_hssthp_cfg_arbiter_v1_0 #(.TIMEOUT(TIMEOUT)) dut (
        .p_cfg_clk (clk),
        .p_cfg_rstn(rstn),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // requester stimulus state
    bit          pend [2];
    bit          p_write [2];
    logic [15:0] p_addr [2];
    logic [7:0]  p_wdata [2];
    bit          random_gen  = 0;
    bit          auto_refill = 0;
    int          force_wait  = -1;
    int          force_brdata = -1;

    // model: current transaction as a timeline relative to its accept edge
    bit          m_busy = 0;
    int          m_rel, m_dlen, m_a, m_w, m_owner;
    bit          m_mapped, m_write;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_brdata;
    bit          m_last_gnt = 1;
    logic [15:0] m_last_addr = 16'h0;
    logic [7:0]  m_last_wdata = 8'h0;
    bit          m_last_write = 0;
    logic [7:0]  m_rdata_out [2];
    bit          m_err_out [2];
    int          txn_done = 0;
    int          gq [$];

    // observations of the current transaction
    int obs_done_rel, obs_psel_cnt, obs_en_cnt;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic dut_done(int i);
        return (i == 1) ? bus.req1_done : bus.req0_done;
    endfunction

    task automatic set_req(int i, bit w, logic [15:0] a, logic [7:0] d);
        pend[i] = 1; p_write[i] = w; p_addr[i] = a; p_wdata[i] = d;
    endtask

    task automatic new_req(int i);
        logic [3:0] tgt;
        tgt = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 6));
        set_req(i, 1'($urandom_range(0, 1)), {tgt, 12'($urandom)}, 8'($urandom));
    endtask

    task automatic drive_reqs();
        bus.req0_valid = pend[0]; bus.req0_write = p_write[0];
        bus.req0_addr  = p_addr[0]; bus.req0_wdata = p_wdata[0];
        bus.req1_valid = pend[1]; bus.req1_write = p_write[1];
        bus.req1_addr  = p_addr[1]; bus.req1_wdata = p_wdata[1];
    endtask

    task automatic model_reset();
        m_busy = 0; m_last_gnt = 1;
        m_last_addr = 16'h0; m_last_wdata = 8'h0; m_last_write = 0;
        for (int i = 0; i < 2; i++) begin
            m_rdata_out[i] = 8'h0; m_err_out[i] = 0; pend[i] = 0;
        end
    endtask

    // One clock cycle: compare registered outputs, drive inputs, check ready
    // and let the model take any acceptance happening at the coming edge.
    task automatic step();
        bit       idle_now;
        bit [1:0] exp_done;
        bit       exp_psel, exp_en, exp_busy;
        int       g;
        @(negedge clk);
        if (m_busy) m_rel++;
        idle_now = !m_busy;
        exp_psel = 0; exp_en = 0; exp_busy = 0; exp_done = 2'b00;
        if (m_busy) begin
            exp_busy = 1;
            exp_psel = m_mapped && (m_rel <= 1 + m_a);
            exp_en   = m_mapped && (m_rel >= 2) && (m_rel <= 1 + m_a);
            if (m_rel == m_dlen) begin
                exp_done[m_owner]    = 1;
                m_err_out[m_owner]   = !m_mapped || (m_w >= TIMEOUT);
                m_rdata_out[m_owner] = (m_err_out[m_owner] || m_write) ? 8'h00 : m_brdata;
            end
            if (bus.p_cfg_psel === 1'b1)   obs_psel_cnt++;
            if (bus.p_cfg_enable === 1'b1) obs_en_cnt++;
            if (dut_done(m_owner) === 1'b1) obs_done_rel = m_rel;
        end
        chk("psel",   bus.p_cfg_psel,   exp_psel);
        chk("enable", bus.p_cfg_enable, exp_en);
        chk("busy",   bus.cfg_busy,     exp_busy);
        chk("done0",  bus.req0_done,    exp_done[0]);
        chk("done1",  bus.req1_done,    exp_done[1]);
        chk("err0",   bus.req0_err,     m_err_out[0]);
        chk("err1",   bus.req1_err,     m_err_out[1]);
        chk("rdata0", bus.req0_rdata,   m_rdata_out[0]);
        chk("rdata1", bus.req1_rdata,   m_rdata_out[1]);
        chk("addr",   bus.p_cfg_addr,   m_last_addr);
        chk("wdata",  bus.p_cfg_wdata,  m_last_wdata);
        chk("write",  bus.p_cfg_write,  m_last_write);
        if (m_busy && m_rel == m_dlen) begin
            $display("txn %0d owner=%0d %s addr=%h wdata=%h waits=%0d err=%0d rdata=%h",
                     txn_done, m_owner, m_write ? "W" : "R", m_addr, m_wdata, m_w,
                     m_err_out[m_owner], m_rdata_out[m_owner]);
            m_busy = 0;
            txn_done++;
        end

        if (random_gen)
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
        drive_reqs();
        if (m_busy && m_mapped && m_rel >= 2 && m_rel <= 1 + m_a) begin
            bus.p_cfg_ready = (m_rel - 2 == m_w);
            bus.p_cfg_rdata = bus.p_cfg_ready ? m_brdata : 8'($urandom);
        end else begin
            bus.p_cfg_ready = 1'($urandom_range(0, 1));
            bus.p_cfg_rdata = 8'($urandom);
        end
        #1;
        g = -1;
        if (idle_now) begin
            if (pend[0] && pend[1]) g = m_last_gnt ? 0 : 1;
            else if (pend[0])       g = 0;
            else if (pend[1])       g = 1;
        end
        chk("ready0", bus.req0_ready, g == 0);
        chk("ready1", bus.req1_ready, g == 1);
        if (g >= 0) begin
            m_busy = 1; m_rel = 0; m_owner = g; m_last_gnt = 1'(g);
            m_write = p_write[g]; m_addr = p_addr[g]; m_wdata = p_wdata[g];
            m_last_addr = m_addr; m_last_wdata = m_wdata; m_last_write = m_write;
            m_mapped = (m_addr[15:12] <= 4);
            m_w      = (force_wait >= 0) ? force_wait : $urandom_range(0, 5);
            m_a      = (m_w < TIMEOUT) ? m_w + 1 : TIMEOUT;
            m_dlen   = m_mapped ? 2 + m_a : 1;
            m_brdata = (force_brdata >= 0) ? 8'(force_brdata) : 8'($urandom);
            obs_done_rel = -1; obs_psel_cnt = 0; obs_en_cnt = 0;
            pend[g] = 0;
            gq.push_back(g);
            if (auto_refill)
                set_req(g, 1'b1, {4'($urandom_range(0, 4)), 12'($urandom)}, 8'($urandom));
        end
    endtask

    task automatic run_txns(int n, int budget);
        int start;
        int cnt;
        start = txn_done;
        cnt = 0;
        while (txn_done < start + n && cnt < budget) begin
            step();
            cnt++;
        end
        chk("txn_budget", txn_done - start, n);
    endtask

    task automatic drain(int budget);
        for (int n = 0; n < budget && (pend[0] || pend[1] || m_busy); n++) step();
        chk("drain", pend[0] | pend[1] | m_busy, 0);
    endtask

    initial begin
        model_reset();
        drive_reqs();
        bus.p_cfg_ready = 1'b0;
        bus.p_cfg_rdata = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_psel",   bus.p_cfg_psel,   0);
        chk("rst_enable", bus.p_cfg_enable, 0);
        chk("rst_write",  bus.p_cfg_write,  0);
        chk("rst_busy",   bus.cfg_busy,     0);
        chk("rst_done0",  bus.req0_done,    0);
        chk("rst_done1",  bus.req1_done,    0);
        chk("rst_err0",   bus.req0_err,     0);
        chk("rst_err1",   bus.req1_err,     0);
        chk("rst_addr",   bus.p_cfg_addr,   0);
        chk("rst_wdata",  bus.p_cfg_wdata,  0);
        chk("rst_rdata0", bus.req0_rdata,   0);
        chk("rst_rdata1", bus.req1_rdata,   0);
        rstn = 1'b1;

        // tie and fairness: back-to-back writes from both
        force_wait = 0;
        set_req(0, 1'b1, 16'h0010, 8'h11);
        set_req(1, 1'b1, 16'h1020, 8'h22);
        auto_refill = 1;
        gq.delete();
        run_txns(4, 60);
        auto_refill = 0;
        for (int k = 0; k < 4; k++)
            chk($sformatf("tie_grant%0d", k), (k < gq.size()) ? gq[k] : 99, k % 2);
        drain(60);

        // single read 0x4010 returning 0xA5 on the first ACCESS cycle
        force_brdata = 8'hA5;
        set_req(0, 1'b0, 16'h4010, 8'h00);
        run_txns(1, 20);
        chk("read_done_cycle", obs_done_rel, 3);
        chk("read_psel_cycles", obs_psel_cnt, 2);
        chk("read_en_cycles", obs_en_cnt, 1);
        chk("read_rdata0", bus.req0_rdata, 8'hA5);
        chk("read_err0", bus.req0_err, 0);
        chk("read_addr", bus.p_cfg_addr, 16'h4010);
        force_brdata = -1;

        // write with three wait states
        force_wait = 3;
        set_req(0, 1'b1, 16'h1234, 8'h3C);
        run_txns(1, 20);
        chk("wait_done_cycle", obs_done_rel, 6);
        chk("wait_en_cycles", obs_en_cnt, 4);
        chk("wait_err0", bus.req0_err, 0);
        chk("wait_wdata", bus.p_cfg_wdata, 8'h3C);

        // timeout: ready never comes
        force_wait = 99;
        set_req(1, 1'b0, 16'h0100, 8'h00);
        run_txns(1, 20);
        chk("to_done_cycle", obs_done_rel, 6);
        chk("to_en_cycles", obs_en_cnt, 4);
        chk("to_err1", bus.req1_err, 1);
        chk("to_rdata1", bus.req1_rdata, 0);
        step();
        chk("to_busy_after", bus.cfg_busy, 0);

        // unmapped target
        set_req(1, 1'b0, 16'h7000, 8'h00);
        run_txns(1, 20);
        chk("unm_done_cycle", obs_done_rel, 1);
        chk("unm_psel_cycles", obs_psel_cnt, 0);
        chk("unm_err1", bus.req1_err, 1);
        force_wait = -1;

        // random traffic
        random_gen = 1;
        repeat (1500) step();
        random_gen = 0;
        drain(200);

        // reset in the middle of ACCESS
        force_wait = 99;
        set_req(0, 1'b0, 16'h2040, 8'h00);
        for (int n = 0; n < 30 && !(m_busy && m_rel == 3); n++) step();
        chk("mid_reached_access", m_busy && m_rel == 3, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_psel", bus.p_cfg_psel, 0);
        chk("mid_enable", bus.p_cfg_enable, 0);
        chk("mid_busy", bus.cfg_busy, 0);
        chk("mid_done0", bus.req0_done, 0);
        model_reset();
        drive_reqs();
        @(negedge clk);
        #1;
        rstn = 1'b1;
        force_wait = 0;
        set_req(0, 1'b1, 16'h3001, 8'h5A);
        set_req(1, 1'b1, 16'h3002, 8'hA5);
        gq.delete();
        step();
        chk("post_reset_tie", (gq.size() > 0) ? gq[0] : 99, 0);
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ipm2t_hssthp_cfg_arbiter_v1_0.md
# ipm2t_hssthp_cfg_arbiter_v1_0

This block is a two-requester APB master arbiter and sequencer that sits directly upstream of the HSSTHP APB bridge on the fabric port. It shares the single configuration port between two clients: requester 0 is the init/DRP sequencer and requester 1 is user logic. It generates the APB setup and access phases itself, applies a ready timeout, and short-circuits accesses to unmapped address regions. Each transaction ends with one completion pulse carrying read data and an error flag.

## Interface
Parameters:
- TIMEOUT, default 255: maximum number of ACCESS cycles to wait for p_cfg_ready. Legal range is 1..255.

Ports (clock and reset first):
- p_cfg_clk  in  1  configuration clock; the only clock.
- p_cfg_rstn  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  request pending (N = 0, 1); held until accepted.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  16  [15:12] target (0–3 = channel, 4 = HPLL), [11:0] register.
- reqN_wdata  in  8  write data.
- reqN_ready  out  1  accept; the request transfers on the edge where valid & ready.
- reqN_done  out  1  one-cycle completion pulse.
- reqN_err  out  1  valid with done; 1 = timeout or unmapped target.
- reqN_rdata  out  8  read result; updated only on that requester's done.
- p_cfg_psel, p_cfg_enable, p_cfg_write  out  1  APB controls toward the bridge.
- p_cfg_addr  out  16  APB address.
- p_cfg_wdata  out  8  APB write data.
- p_cfg_ready  in  1  APB ready from the bridge.
- p_cfg_rdata  in  8  APB read data from the bridge.
- cfg_busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, SETUP, ACCESS, RESP. All outputs are registered except reqN_ready.
- **IDLE:**
  - reqN_ready = grantN, combinational; this is the only state where any ready can be high.
  - If only one requester is valid, it is granted.
  - If both are valid, grant the index that is not in last_gnt (round-robin). After reset last_gnt = 1, so requester 0 wins the first tie.
  - On acceptance: latch write, addr and wdata into the p_cfg_* registers; set owner = N; set last_gnt = N.
  - Next state is SETUP if addr[15:12] ≤ 4. Otherwise next state is RESP with err = 1, and no APB phase is issued.
- **SETUP:** psel = 1, enable = 0 for exactly one cycle; next state is ACCESS. Clear the timeout counter.
- **ACCESS:**
  - psel = 1, enable = 1.
  - If p_cfg_ready = 1: capture p_cfg_rdata when the access is a read (0 when it is a write), set err = 0, go to RESP.
  - Otherwise increment the counter. When the counter equals TIMEOUT-1 and ready is still 0, go to RESP with err = 1 and rdata = 0.
  - A ready seen in the same cycle as the timeout limit is treated as success.
- **RESP:**
  - psel = enable = 0.
  - owner_done = 1 for one cycle. owner_err and owner_rdata are updated in that same cycle; the other requester's outputs are unchanged.
  - Next state is IDLE.
- p_cfg_addr, p_cfg_wdata and p_cfg_write hold their last values outside transactions. They are stable from SETUP through the end of ACCESS.
- A requester that is not granted keeps valid asserted; no request is ever dropped.

## Timing
- Reset (asynchronous assert) forces immediately:
  - state = IDLE, last_gnt = 1, counter = 0;
  - psel, enable, write, cfg_busy, reqN_done, reqN_err = 0;
  - p_cfg_addr = 0, p_cfg_wdata = 0, reqN_rdata = 0.
  - No done pulse is issued for an in-flight access.
- Mapped access with ready on the first ACCESS cycle (T0 is the accept edge):
  - SETUP in cycle 1, ACCESS in cycle 2, done in cycle 3.
  - IDLE in cycle 4; earliest next accept is at the end of cycle 4.
- Minimum spacing between accepts is 4 cycles.
- Unmapped access: done with err = 1 in cycle 1, IDLE in cycle 2.
- Timeout: ACCESS lasts exactly TIMEOUT cycles; done occurs in cycle 2 + TIMEOUT.
- A new valid arriving during RESP is not accepted until IDLE.
- cfg_busy = 1 from cycle 1 through RESP.

## Test plan
- **Single read:** req0 reads 0x4010 and the bridge returns ready on the first ACCESS cycle with rdata 0xA5.
  - Required: psel in cycles 1–2, enable in cycle 2, p_cfg_addr = 0x4010, done0 in cycle 3, rdata0 = 0xA5, err0 = 0.
- **Tie and fairness:** both requesters assert valid after reset, each issuing back-to-back writes.
  - Required: grant order is 0, 1, 0, 1; each done goes only to its owner; p_cfg_wdata matches the owner's data.
- **Wait states:** a write to 0x1234 with data 0x3C, and ready held low for 3 ACCESS cycles.
  - Required: ACCESS lasts 4 cycles with p_cfg_wdata = 0x3C stable throughout; done in cycle 6 with err = 0.
- **Timeout:** TIMEOUT = 4, ready never asserts.
  - Required: exactly 4 ACCESS cycles, then done with err = 1 and rdata = 0; cfg_busy falls afterward.
- **Unmapped:** req1 reads 0x7000.
  - Required: psel never rises; done1 with err1 = 1 one cycle after accept.
- **Reset mid-ACCESS:** p_cfg_rstn goes low during ACCESS.
  - Required: psel and enable drop immediately and no done pulse occurs; after release, req0 wins the next tie.
